andor_share_arbiter: RTL and testbench
======================================

Name: andor_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational AND/OR evaluation unit (X = A & B, Y = B | C, 10-time-unit propagation delay) among NUM_REQ requesters.
- For each accepted request, the block:
  - drives the unit's inputs,
  - holds them for a programmable settle window covering the unit delay,
  - captures X/Y and returns them, tagged with the requester ID, on a valid/ready response channel.
- Sits between requester logic and the single shared unit instance.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- SETTLE_CYCLES, 2: clock cycles the unit inputs are held before X/Y are sampled (>=1); the clock period times SETTLE_CYCLES must exceed the unit delay.
- ID_W, $clog2(NUM_REQ): width of the response ID.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request strobe.
- req_abc  in  3*NUM_REQ  operands; bits [3i+2:3i] = {A,B,C} for requester i.
- req_ready  out  NUM_REQ  one-hot accept pulse to the granted requester.
- unit_a, unit_b, unit_c  out  1 each  inputs to the shared unit.
- unit_x, unit_y  in  1 each  outputs from the shared unit.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester whose result is presented.
- rsp_xy  out  2  captured {X,Y}.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE;
  - unit_a/b/c = 0; rsp_valid = 0; rsp_xy = 0; rsp_id = 0; req_ready = 0;
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - If any req_valid is high, the winner is the first requester with req_valid set, searching from last_grant+1 upward with wrap-around.
  - req_ready[winner] = 1 combinationally in that cycle only; all other bits are 0.
  - On that clock edge (the accept edge t0):
    - unit_a/b/c <= req_abc of the winner;
    - rsp_id <= winner; last_grant <= winner;
    - counter <= SETTLE_CYCLES; state -> SETTLE.
  - With no req_valid: stay in IDLE, req_ready = 0.
- SETTLE:
  - Counter decrements each cycle; unit inputs are held stable.
  - On the edge where the counter equals 1 (edge t0+SETTLE_CYCLES):
    - rsp_xy <= {unit_x, unit_y}; rsp_valid <= 1; state -> RESP.
- RESP:
  - rsp_valid, rsp_xy, rsp_id and the unit inputs are held stable while rsp_ready = 0.
  - On an edge with rsp_ready = 1: rsp_valid <= 0; state -> IDLE.
- Latency and throughput:
  - rsp_valid rises SETTLE_CYCLES cycles after the accept edge.
  - Throughput is one operation per SETTLE_CYCLES+2 cycles when rsp_ready is tied high.
- req_ready is never asserted outside IDLE; requests arriving during SETTLE/RESP wait and are not lost.
- A requester dropping req_valid before it is granted has no effect on anyone else.
- req_abc is sampled only on the accept edge; later changes are ignored.
- Reset mid-operation: outputs return to reset values immediately (asynchronously), the in-flight operation is discarded with no response, and priority returns to requester 0.

Test Plan:
- SETTLE_CYCLES=2, req_valid[0]=1, abc0=3'b110, rsp_ready=1 -> req_ready=4'b0001 for 1 cycle; unit_a/b/c=1/1/0; rsp_valid high 2 cycles after the accept edge with rsp_xy=2'b11, rsp_id=0; it drops after 1 cycle.
- req2 abc=3'b001 -> rsp_xy=2'b01, rsp_id=2; req3 abc=3'b000 -> rsp_xy=2'b00; req1 abc=3'b100 -> rsp_xy=2'b00.
- All 4 req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0,1; accept pulses spaced exactly 4 cycles apart.
- rsp_ready=0 for 5 cycles during RESP -> rsp_valid/rsp_xy/rsp_id stable, busy=1, req_ready=0 throughout; a pending req is accepted in the cycle after the handshake edge.
- last_grant=1 with req_valid=4'b1010 simultaneously -> requester 3 granted, then 1.
- rst_n pulsed low during SETTLE -> rsp_valid=0 and unit inputs=0 immediately, no response emitted; next grant with req_valid=4'b1111 goes to requester 0.

Source files
------------

// File: rtl/andor_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational AND/OR unit (X = A & B, Y = B | C)
// among NUM_REQ requesters, returning each tagged result on a valid/ready channel.
module andor_share_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int SETTLE_CYCLES = 2,
   parameter int ID_W          = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [3*NUM_REQ-1:0] req_abc,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 unit_a,
   output logic                 unit_b,
   output logic                 unit_c,
   input  logic                 unit_x,
   input  logic                 unit_y,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [1:0]           rsp_xy,
   output logic                 busy
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [ID_W-1:0]  last_grant;
   logic [ID_W-1:0]  winner;
   logic             grant_found;

   // Search starts one past the previous winner and wraps, giving rotating priority.
   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      grant_found = 1'b0;
      winner      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         int idx;
         idx = (int'(last_grant) + k) % NUM_REQ;
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            winner      = ID_W'(idx);
         end
      end
   end

   // Accept pulse is gated by rst_n so it reads 0 while reset is held.
   always_comb begin
      req_ready = '0;
      if (rst_n && state == IDLE && grant_found)
         req_ready[winner] = 1'b1;
   end

   assign busy = (state != IDLE);

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         count      <= '0;
         last_grant <= ID_W'(NUM_REQ - 1);
         unit_a     <= 1'b0;
         unit_b     <= 1'b0;
         unit_c     <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_xy     <= '0;
         rsp_id     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  {unit_a, unit_b, unit_c} <= req_abc[3*int'(winner) +: 3];
                  rsp_id     <= winner;
                  last_grant <= winner;
                  count      <= CNT_W'(SETTLE_CYCLES);
                  state      <= SETTLE;
               end
            end
            SETTLE: begin
               // Unit inputs have been stable for SETTLE_CYCLES edges; X/Y are now valid.
               if (count == CNT_W'(1)) begin
                  rsp_xy    <= {unit_x, unit_y};
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  count <= count - CNT_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_andor_share_arbiter.sv
// Directed bench for andor_share_arbiter: models the shared unit with a 10-unit delay
// and walks through single ops, round-robin, back-pressure and mid-operation reset.
module tb_andor_share_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NUM_REQ-1:0] req_valid;
   logic [3*NUM_REQ-1:0] req_abc;
   logic [NUM_REQ-1:0] req_ready;
   logic               unit_a, unit_b, unit_c;
   logic               unit_x = 1'b0;
   logic               unit_y = 1'b0;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [ID_W-1:0]    rsp_id;
   logic [1:0]         rsp_xy;
   logic               busy;

   int checks = 0;
   int errors = 0;

   andor_share_arbiter #(.NUM_REQ(NUM_REQ), .SETTLE_CYCLES(2), .ID_W(ID_W)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_abc(req_abc),
      .req_ready(req_ready), .unit_a(unit_a), .unit_b(unit_b), .unit_c(unit_c),
      .unit_x(unit_x), .unit_y(unit_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_xy(rsp_xy), .busy(busy)
   );

   always #5 clk = ~clk;

   // Shared AND/OR unit with 10 time units of propagation delay.
   always @(unit_a or unit_b or unit_c) begin
      unit_x <= #10 (unit_a & unit_b);
      unit_y <= #10 (unit_b | unit_c);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_abc(input int i, input logic [2:0] v);
      req_abc[3*i +: 3] = v;
   endtask

   // Entered in IDLE with inputs already driven; runs one full op with rsp_ready high.
   task automatic op(input string tag, input logic [3:0] exp_rr, input logic [1:0] exp_id,
                     input logic [2:0] exp_abc, input logic [1:0] exp_xy,
                     input logic [3:0] valid_after);
      #1;
      chk({tag, "_rr"}, req_ready, exp_rr);
      chk({tag, "_idle"}, busy, 1'b0);
      @(posedge clk); #1;
      req_valid = valid_after;
      chk({tag, "_unit"}, {unit_a, unit_b, unit_c}, exp_abc);
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_rr_off"}, req_ready, 4'b0000);
      @(posedge clk); #1;
      chk({tag, "_early"}, rsp_valid, 1'b0);
      @(posedge clk); #1;
      chk({tag, "_valid"}, rsp_valid, 1'b1);
      chk({tag, "_xy"}, rsp_xy, exp_xy);
      chk({tag, "_id"}, rsp_id, exp_id);
      @(posedge clk); #1;
      chk({tag, "_drop"}, rsp_valid, 1'b0);
      @(negedge clk);
   endtask

   initial begin
      int exp_order [6] = '{0, 1, 2, 3, 0, 1};
      int g;
      int last_cyc;

      rst_n = 1'b0; req_valid = '0; req_abc = '0; rsp_ready = 1'b1;
      #1;
      chk("rst_valid", rsp_valid, 1'b0);
      chk("rst_xy", rsp_xy, 2'b00);
      chk("rst_id", rsp_id, 2'd0);
      chk("rst_unit", {unit_a, unit_b, unit_c}, 3'b000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rr", req_ready, 4'b0000);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      // Single requesters.
      set_abc(0, 3'b110); req_valid = 4'b0001;
      op("r0", 4'b0001, 2'd0, 3'b110, 2'b11, 4'b0000);
      set_abc(2, 3'b001); req_valid = 4'b0100;
      op("r2", 4'b0100, 2'd2, 3'b001, 2'b01, 4'b0000);
      set_abc(3, 3'b000); req_valid = 4'b1000;
      op("r3", 4'b1000, 2'd3, 3'b000, 2'b00, 4'b0000);
      set_abc(1, 3'b100); req_valid = 4'b0010;
      op("r1", 4'b0010, 2'd1, 3'b100, 2'b00, 4'b0000);

      // last_grant is 1: requester 3 wins over 1, then 1 follows.
      set_abc(3, 3'b011); set_abc(1, 3'b110); req_valid = 4'b1010;
      op("lg3", 4'b1000, 2'd3, 3'b011, 2'b01, 4'b0010);
      op("lg1", 4'b0010, 2'd1, 3'b110, 2'b11, 4'b0000);

      // Round-robin after reset with all requesters asserting.
      rst_n = 1'b0; #2; rst_n = 1'b1;
      @(negedge clk);
      req_valid = 4'b1111;
      g = 0; last_cyc = -1;
      for (int cyc = 0; cyc < 40 && g < 6; cyc++) begin
         #1;
         if (req_ready != 4'b0000) begin
            chk("rr_grant", req_ready, 32'd1 << exp_order[g]);
            if (g > 0) chk("rr_spacing", cyc - last_cyc, 4);
            last_cyc = cyc;
            g++;
         end
         @(negedge clk);
      end
      chk("rr_count", g, 6);
      req_valid = '0;
      repeat (6) @(negedge clk);

      // Back-pressure in RESP with requester 0 waiting.
      set_abc(2, 3'b111); set_abc(0, 3'b010); req_valid = 4'b0100; rsp_ready = 1'b0;
      #1; chk("bp_rr", req_ready, 4'b0100);
      @(posedge clk); #1;
      req_valid = 4'b0001;
      chk("bp_rr_settle", req_ready, 4'b0000);
      @(posedge clk); #1;
      chk("bp_early", rsp_valid, 1'b0);
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_valid", rsp_valid, 1'b1);
         chk("bp_xy", rsp_xy, 2'b11);
         chk("bp_id", rsp_id, 2'd2);
         chk("bp_busy", busy, 1'b1);
         chk("bp_rr_hold", req_ready, 4'b0000);
         @(posedge clk);
      end
      #1; rsp_ready = 1'b1;
      chk("bp_unit_hold", {unit_a, unit_b, unit_c}, 3'b111);
      @(posedge clk); #1;
      chk("bp_done", rsp_valid, 1'b0);
      op("pend", 4'b0001, 2'd0, 3'b010, 2'b01, 4'b0000);

      // Reset during SETTLE discards the op and restores priority to requester 0.
      set_abc(1, 3'b111); req_valid = 4'b1111;
      #1; chk("mr_rr", req_ready, 4'b0010);
      @(posedge clk); #3;
      rst_n = 1'b0; req_valid = '0;
      #1;
      chk("mr_valid", rsp_valid, 1'b0);
      chk("mr_unit", {unit_a, unit_b, unit_c}, 3'b000);
      chk("mr_busy", busy, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("mr_no_rsp", rsp_valid, 1'b0);
         chk("mr_idle", busy, 1'b0);
      end
      @(negedge clk);
      set_abc(0, 3'b011); req_valid = 4'b1111;
      op("post_rst", 4'b0001, 2'd0, 3'b011, 2'b01, 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
